// File: rtl/core_mem_arbiter_pkg.sv
// rtl/core_mem_arbiter_pkg.sv - shared types and constants for the data/fetch memory arbiter
package core_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_D = 2'd1,
    BUSY_I = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  typedef enum logic {
    GNT_D = 1'b0,
    GNT_I = 1'b1
  } arb_gnt_e;

  // Read data returned to the requester when the memory never answers.
  localparam logic [31:0] ARB_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/arb_timeout_cnt.sv
// rtl/arb_timeout_cnt.sv - per-transaction wait counter that flags expiry after TIMEOUT busy cycles
module arb_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  // Expiry is the TIMEOUT-th busy cycle, so the count stops one short of TIMEOUT.
  assign expire_o = en_i && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (load_i) begin
      cnt <= '0;
    end else if (en_i && !expire_o) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// rtl/core_mem_arbiter.sv - shares one memory port between data and fetch requesters with timeout
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module core_mem_arbiter
  import core_mem_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int TIMEOUT    = 255,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic [DW-1:0] d_rdata_o,
  output logic          d_ready_o,
  input  logic          i_req_i,
  input  logic [AW-1:0] i_addr_i,
  output logic [DW-1:0] i_rdata_o,
  output logic          i_ready_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ready_i,
  output logic          hold_o,
  output logic          err_o
);

  if (STARVE_MAX < 1) begin : g_starve_max_check
    $error("STARVE_MAX must be at least 1");
  end

  arb_state_e    state, state_nxt;
  arb_gnt_e      gnt_q, gnt_nxt;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] d_rdata_q;
  logic [DW-1:0] i_rdata_q;
  logic          err_q;
  logic          grant_d;
  logic          grant_i;
  logic          busy;
  logic          to_expire;
  logic          done;
  logic          starve_force;
  logic [DW-1:0] resp_data;

  assign busy      = (state == BUSY_D) || (state == BUSY_I);
  assign done      = busy && (mem_ready_i || to_expire);
  assign resp_data = mem_ready_i ? mem_rdata_i : DW'(ARB_ERR_DATA);

  if (TIMEOUT != 0) begin : g_timeout
    arb_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
    ) u_timeout (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .load_i   (grant_d || grant_i),
      .en_i     (busy),
      .expire_o (to_expire)
    );
  end else begin : g_no_timeout
    assign to_expire = 1'b0;
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt;

  assign starve_force = (state == IDLE) && d_req_i && i_req_i &&
                        (starve_cnt == SW'(STARVE_MAX));

  // Saturation is never needed: at STARVE_MAX with fetch pending, fetch wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_cnt <= '0;
    end else if (grant_i) begin
      starve_cnt <= '0;
    end else if (grant_d) begin
      starve_cnt <= i_req_i ? starve_cnt + SW'(1) : '0;
    end
  end
`else
  assign starve_force = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_q;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    case (state)
      IDLE: begin
        if (d_req_i && !starve_force) begin
          grant_d   = 1'b1;
          gnt_nxt   = GNT_D;
          state_nxt = BUSY_D;
        end else if (i_req_i) begin
          grant_i   = 1'b1;
          gnt_nxt   = GNT_I;
          state_nxt = BUSY_I;
        end
      end
      BUSY_D, BUSY_I: begin
        if (mem_ready_i || to_expire) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      gnt_q     <= GNT_D;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      d_rdata_q <= '0;
      i_rdata_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt_q <= gnt_nxt;
      if (grant_d) begin
        we_q    <= d_we_i;
        addr_q  <= d_addr_i;
        wdata_q <= d_wdata_i;
      end else if (grant_i) begin
        we_q    <= 1'b0;
        addr_q  <= i_addr_i;
        wdata_q <= '0;
      end
      // A real completion in the expiry cycle takes precedence over the error.
      if (done) begin
        err_q <= !mem_ready_i;
        if (gnt_q == GNT_D) begin
          d_rdata_q <= resp_data;
        end else begin
          i_rdata_q <= resp_data;
        end
      end
    end
  end

  assign mem_req_o   = busy;
  assign mem_we_o    = busy && we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  assign d_rdata_o = d_rdata_q;
  assign i_rdata_o = i_rdata_q;
  assign d_ready_o = (state == RESP) && (gnt_q == GNT_D);
  assign i_ready_o = (state == RESP) && (gnt_q == GNT_I);
  assign err_o     = (state == RESP) && err_q;

  assign hold_o = !rst_i && d_req_i && !((state == RESP) && (gnt_q == GNT_D));

endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb/tb_core_mem_arbiter.sv - directed self-checking bench for core_mem_arbiter (TIMEOUT=8)
`timescale 1ns/1ps
module tb_core_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_req, d_we, d_ready;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        i_req, i_ready;
  logic [31:0] i_addr, i_rdata;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        hold, err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  core_mem_arbiter #(
    .AW(32), .DW(32), .TIMEOUT(8), .STARVE_MAX(4)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_rdata_o(d_rdata), .d_ready_o(d_ready),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_rdata_o(i_rdata), .i_ready_o(i_ready),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready),
    .hold_o(hold), .err_o(err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic        seen;
  logic        exp_d;

  initial begin
    rst = 1'b1;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    i_req = 0; i_addr = 0; mem_ready = 0; mem_rdata = 0;
    tick(); tick();
    check("rst_mem_req", mem_req, 0);
    check("rst_outputs", {d_ready, i_ready, hold, err, mem_we}, 5'b0);
    check("rst_rdata", {d_rdata, i_rdata}, 64'h0);
    rst = 1'b0;
    tick();

    // single data read, memory answers one cycle after mem_req
    d_req = 1; d_addr = 32'h1000_0004; settle();
    check("rd_c0_hold", hold, 1);
    check("rd_c0_memreq", mem_req, 0);
    tick();
    check("rd_c1_memreq", mem_req, 1);
    check("rd_c1_addr", mem_addr, 32'h1000_0004);
    check("rd_c1_we", mem_we, 0);
    tick();
    mem_ready = 1; mem_rdata = 32'h1234_5678; settle();
    check("rd_c2_hold", hold, 1);
    tick();
    mem_ready = 0; mem_rdata = 0; settle();
    check("rd_c3_dready", d_ready, 1);
    check("rd_c3_rdata", d_rdata, 32'h1234_5678);
    check("rd_c3_iready", i_ready, 0);
    check("rd_c3_hold", hold, 0);
    check("rd_c3_memreq", mem_req, 0);
    tick();
    d_req = 0; settle();
    check("rd_c4_dready", d_ready, 0);
    check("rd_c4_rdata_held", d_rdata, 32'h1234_5678);

    // simultaneous requests: data first, fetch granted when IDLE returns
    d_req = 1; d_addr = 32'h1000_0100; i_req = 1; i_addr = 32'h0000_0200; settle();
    tick();
    check("sim_c1_addr", mem_addr, 32'h1000_0100);
    tick();
    mem_ready = 1; mem_rdata = 32'hAAAA_0001;
    tick();
    mem_ready = 0; settle();
    check("sim_c3_dready", d_ready, 1);
    check("sim_c3_iready", i_ready, 0);
    check("sim_c3_rdata", d_rdata, 32'hAAAA_0001);
    tick();
    d_req = 0; settle();
    check("sim_c4_idle", mem_req, 0);
    tick();
    check("sim_c5_memreq", mem_req, 1);
    check("sim_c5_addr", mem_addr, 32'h0000_0200);
    check("sim_c5_we", mem_we, 0);
    mem_ready = 1; mem_rdata = 32'hBBBB_0002;
    tick();
    mem_ready = 0; settle();
    check("sim_c6_iready", i_ready, 1);
    check("sim_c6_irdata", i_rdata, 32'hBBBB_0002);
    check("sim_c6_dready", d_ready, 0);
    tick();
    i_req = 0;

    // data write: latched wdata held until mem_ready
    d_req = 1; d_we = 1; d_addr = 32'h1000_0008; d_wdata = 32'hCAFE_0001; settle();
    tick();
    check("wr_c1_we", mem_we, 1);
    check("wr_c1_wdata", mem_wdata, 32'hCAFE_0001);
    tick();
    d_wdata = 32'h0; settle();
    check("wr_c2_wdata_latched", mem_wdata, 32'hCAFE_0001);
    check("wr_c2_we", mem_we, 1);
    mem_ready = 1;
    tick();
    mem_ready = 0; settle();
    check("wr_c3_dready", d_ready, 1);
    check("wr_c3_iready", i_ready, 0);
    check("wr_c3_err", err, 0);
    tick();
    d_req = 0; d_we = 0; settle();
    check("wr_c4_dready", d_ready, 0);

    // timeout: no response, error completion 9 cycles after grant
    d_req = 1; d_addr = 32'h1000_0010; settle();
    seen = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (!mem_req || d_ready) seen = 1;
    end
    check("to_busy_8_cycles", seen, 0);
    tick();
    check("to_c9_dready", d_ready, 1);
    check("to_c9_err", err, 1);
    check("to_c9_rdata", d_rdata, 32'hDEAD_BEEF);
    tick();
    d_req = 0; mem_ready = 1; mem_rdata = 32'h1111_1111; settle();
    check("to_c10_err", err, 0);
    tick();
    mem_ready = 0; settle();
    check("stray_ready_ignored", {d_ready, i_ready, mem_req}, 3'b0);
    check("stray_rdata_kept", d_rdata, 32'hDEAD_BEEF);

    // mem_ready on the expiry cycle completes normally
    d_req = 1; d_addr = 32'h1000_0014; settle();
    for (int c = 1; c <= 7; c++) tick();
    tick();
    mem_ready = 1; mem_rdata = 32'h5555_AAAA;
    tick();
    mem_ready = 0; settle();
    check("tor_c9_dready", d_ready, 1);
    check("tor_c9_err", err, 0);
    check("tor_c9_rdata", d_rdata, 32'h5555_AAAA);
    tick();
    d_req = 0;

    // reset while a fetch is in flight
    i_req = 1; i_addr = 32'h2000_0010; settle();
    tick();
    check("rs_c1_memreq", mem_req, 1);
    tick();
    rst = 1; settle();
    check("rs_memreq", mem_req, 0);
    check("rs_outputs", {i_ready, d_ready, err, hold, mem_we}, 5'b0);
    check("rs_addr", mem_addr, 32'h0);
    i_req = 0;
    tick(); tick();
    rst = 0;
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (i_ready) seen = 1;
    end
    check("rs_no_iready", seen, 0);
    d_req = 1; d_addr = 32'h3000_0000; settle();
    tick();
    check("rs_new_memreq", mem_req, 1);
    check("rs_new_addr", mem_addr, 32'h3000_0000);
    mem_ready = 1; mem_rdata = 32'h0BAD_F00D;
    tick();
    mem_ready = 0; settle();
    check("rs_new_dready", d_ready, 1);
    check("rs_new_rdata", d_rdata, 32'h0BAD_F00D);
    tick();
    d_req = 0;
    tick();

    // both requests held continuously
    d_req = 1; d_addr = 32'h4000_0000; i_req = 1; i_addr = 32'h5000_0000; settle();
    for (int k = 0; k < 10; k++) begin
`ifdef ARB_STARVE_GUARD_EN
      exp_d = (k % 5) != 4;
`else
      exp_d = 1'b1;
`endif
      tick();
      check("pri_memreq", mem_req, 1);
      check("pri_grant_is_data", mem_addr == 32'h4000_0000, exp_d);
      mem_ready = 1; mem_rdata = 32'h6000_0000 + k;
      tick();
      mem_ready = 0; settle();
      check("pri_ready", {d_ready, i_ready}, exp_d ? 2'b10 : 2'b01);
      tick();
    end
    d_req = 0; i_req = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
